// File: rtl/writeback_stage_if.sv
// Writeback stage bus: instruction-in side, register-file/forwarding side,
// pipeline control and the retire counter.
interface writeback_stage_if #(
    parameter int XLEN       = 32,
    parameter int NUM_SRC    = 4,
    parameter int SEL_W      = $clog2(NUM_SRC),
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 64
);
    logic                      in_valid;
    logic                      in_ready;
    logic                      stall;
    logic                      flush;
    logic [NUM_SRC*XLEN-1:0]   SrcData;
    logic [SEL_W-1:0]          ResultSrc;
    logic [2:0]                LoadFunct3;
    logic [1:0]                ByteOffset;
    logic                      RegWrite;
    logic [REG_ADDR_W-1:0]     Rd;
    logic                      rf_we;
    logic [REG_ADDR_W-1:0]     rf_waddr;
    logic [XLEN-1:0]           rf_wdata;
    logic                      fwd_valid;
    logic                      load_fault;
    logic [CNT_W-1:0]          retired;

    // The writeback stage itself
    modport slave (
        input  in_valid, stall, flush, SrcData, ResultSrc, LoadFunct3,
               ByteOffset, RegWrite, Rd,
        output in_ready, rf_we, rf_waddr, rf_wdata, fwd_valid, load_fault,
               retired
    );

    // The execute/memory side feeding the stage and consuming its results
    modport master (
        output in_valid, stall, flush, SrcData, ResultSrc, LoadFunct3,
               ByteOffset, RegWrite, Rd,
        input  in_ready, rf_we, rf_waddr, rf_wdata, fwd_valid, load_fault,
               retired
    );
endinterface

// File: rtl/writeback_stage.sv
// Register-writeback stage: picks one of NUM_SRC results, formats load data
// by width/sign/byte lane, flags bad loads, drops x0 writes, and registers
// the register-file write port one cycle after acceptance. Also counts
// retired instructions.
module writeback_stage #(
    parameter int XLEN       = 32,
    parameter int NUM_SRC    = 4,
    parameter int SEL_W      = $clog2(NUM_SRC),
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    writeback_stage_if.slave  wb
);

    // Extract the addressed byte/half/word and extend it to XLEN.
    function automatic logic [XLEN-1:0] fmtLoad(
        input logic [XLEN-1:0] raw,
        input logic [2:0]      f3,
        input logic [1:0]      off
    );
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] w;
        b = raw[{off, 3'b000} +: 8];
        h = raw[{off[1], 4'b0000} +: 16];
        w = raw[31:0];
        case (f3)
            3'b000:  fmtLoad = XLEN'(b);
            3'b001:  fmtLoad = XLEN'(h);
            3'b010:  fmtLoad = XLEN'(w);
            3'b100:  fmtLoad = XLEN'($unsigned(b));
            3'b101:  fmtLoad = XLEN'($unsigned(h));
            default: fmtLoad = '0;
        endcase
    endfunction

    // Illegal load encodings and lane misalignment.
    function automatic logic isFault(
        input logic [2:0] f3,
        input logic [1:0] off
    );
        case (f3)
            3'b000, 3'b100: isFault = 1'b0;
            3'b001, 3'b101: isFault = off[0];
            3'b010:         isFault = (off != 2'b00);
            default:        isFault = 1'b1;
        endcase
    endfunction

    logic            vld_p0;
    logic            isLoad_p0;
    logic            fault_p0;
    logic            we_p0;
    logic [XLEN-1:0] selData_p0;

    assign wb.in_ready  = !wb.stall;
    assign wb.fwd_valid = wb.rf_we;

    // ---- stage p0: source select, load formatting, write qualification ----
    // Combinational decode of the presented instruction.
    always_comb begin
        selData_p0 = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (wb.ResultSrc == SEL_W'(k)) begin
                selData_p0 = (k == 1)
                    ? fmtLoad(wb.SrcData[k*XLEN +: XLEN], wb.LoadFunct3, wb.ByteOffset)
                    : wb.SrcData[k*XLEN +: XLEN];
            end
        end
        isLoad_p0 = (wb.ResultSrc == SEL_W'(1));
        fault_p0  = isLoad_p0 && isFault(wb.LoadFunct3, wb.ByteOffset);
        vld_p0    = wb.in_valid && !wb.stall && !wb.flush;
        we_p0     = vld_p0 && wb.RegWrite && (wb.Rd != '0) && !fault_p0;
    end

    // ---- stage p1: registered write port, fault pulse and retire count ----
    // Output register; address/data hold between accepts so a write never repeats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb.rf_we      <= 1'b0;
            wb.load_fault <= 1'b0;
            wb.rf_waddr   <= '0;
            wb.rf_wdata   <= '0;
            wb.retired    <= '0;
        end else begin
            wb.rf_we      <= we_p0;
            wb.load_fault <= vld_p0 && fault_p0;
            if (vld_p0) begin
                wb.rf_waddr <= wb.Rd;
                wb.rf_wdata <= selData_p0;
                wb.retired  <= wb.retired + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed testbench for writeback_stage (retire counter narrowed to 4 bits
// so the wrap-around case is reachable in a short run).
module tb_writeback_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   expRet;

    writeback_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) wb ();

    writeback_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one instruction (does not advance time).
    task automatic drive(input logic [1:0] src, input logic [2:0] f3,
                         input logic [1:0] off, input logic [4:0] rd,
                         input logic regWr);
        wb.in_valid   = 1'b1;
        wb.ResultSrc  = src;
        wb.LoadFunct3 = f3;
        wb.ByteOffset = off;
        wb.Rd         = rd;
        wb.RegWrite   = regWr;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wb.stall = 1'b0;
        wb.flush = 1'b0;
        wb.SrcData = {32'hDEAD_BEEF, 32'h0000_0104, 32'h80FF_7F01, 32'h0000_1234};
        drive(2'd0, 3'b000, 2'd0, 5'd3, 1'b1);
        step();
        step();
        checks++; if (wb.rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got %0b want 0", wb.rf_we); end
        checks++; if (wb.rf_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", wb.rf_wdata); end
        checks++; if (wb.rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr got %0d want 0", wb.rf_waddr); end
        checks++; if (wb.load_fault !== 1'b0 || wb.fwd_valid !== 1'b0) begin errors++; $display("FAIL reset_fault_fwd got %0b/%0b want 0/0", wb.load_fault, wb.fwd_valid); end
        checks++; if (wb.retired !== 4'd0) begin errors++; $display("FAIL reset_retired got %0d want 0", wb.retired); end
        @(negedge clk);
        rst_n = 1'b1;
        wb.in_valid = 1'b0;
        step();
        checks++; if (wb.retired !== 4'd0 || wb.rf_we !== 1'b0) begin errors++; $display("FAIL reset_drop got ret=%0d we=%0b want 0/0", wb.retired, wb.rf_we); end
        expRet = 0;
    endtask

    task automatic test_src_select();
        drive(2'd0, 3'b000, 2'd0, 5'd5, 1'b1);
        #1;
        checks++; if (wb.in_ready !== 1'b1) begin errors++; $display("FAIL in_ready got %0b want 1", wb.in_ready); end
        step();
        wb.in_valid = 1'b0;
        expRet++;
        checks++; if (wb.rf_we !== 1'b1 || wb.fwd_valid !== 1'b1) begin errors++; $display("FAIL alu_we got %0b/%0b want 1/1", wb.rf_we, wb.fwd_valid); end
        checks++; if (wb.rf_waddr !== 5'd5) begin errors++; $display("FAIL alu_waddr got %0d want 5", wb.rf_waddr); end
        checks++; if (wb.rf_wdata !== 32'h0000_1234) begin errors++; $display("FAIL alu_wdata got %h want 00001234", wb.rf_wdata); end
        checks++; if (wb.retired !== 4'd1) begin errors++; $display("FAIL alu_retired got %0d want 1", wb.retired); end
        drive(2'd2, 3'b000, 2'd0, 5'd6, 1'b1);
        step();
        wb.in_valid = 1'b0;
        expRet++;
        checks++; if (wb.rf_wdata !== 32'h0000_0104 || wb.rf_waddr !== 5'd6) begin errors++; $display("FAIL pc4_wdata got %h rd=%0d want 00000104 rd=6", wb.rf_wdata, wb.rf_waddr); end
        drive(2'd3, 3'b011, 2'd0, 5'd8, 1'b1);
        step();
        wb.in_valid = 1'b0;
        expRet++;
        checks++; if (wb.rf_wdata !== 32'hDEAD_BEEF || wb.rf_we !== 1'b1 || wb.load_fault !== 1'b0) begin errors++; $display("FAIL imm_wdata got %h we=%0b flt=%0b want deadbeef 1 0", wb.rf_wdata, wb.rf_we, wb.load_fault); end
        step();
        checks++; if (wb.rf_we !== 1'b0 || wb.rf_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL idle_hold got we=%0b %h want 0 deadbeef", wb.rf_we, wb.rf_wdata); end
    endtask

    task automatic test_load_format();
        logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [1:0]  offs [5] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0};
        logic [31:0] exps [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                                  32'h0000_7F01, 32'h80FF_7F01};
        for (int i = 0; i < 5; i++) begin
            drive(2'd1, f3s[i], offs[i], 5'd7, 1'b1);
            step();
            wb.in_valid = 1'b0;
            expRet++;
            checks++;
            if (wb.rf_wdata !== exps[i] || wb.rf_we !== 1'b1 || wb.load_fault !== 1'b0) begin
                errors++;
                $display("FAIL load_fmt[%0d] got %h we=%0b flt=%0b want %h 1 0", i, wb.rf_wdata, wb.rf_we, wb.load_fault, exps[i]);
            end
        end
    endtask

    task automatic test_faults();
        logic [2:0] f3s  [3] = '{3'b010, 3'b011, 3'b001};
        logic [1:0] offs [3] = '{2'd2, 2'd0, 2'd1};
        for (int i = 0; i < 3; i++) begin
            drive(2'd1, f3s[i], offs[i], 5'd4, 1'b1);
            step();
            wb.in_valid = 1'b0;
            expRet++;
            checks++;
            if (wb.load_fault !== 1'b1 || wb.rf_we !== 1'b0 || wb.retired !== CNT_W'(expRet)) begin
                errors++;
                $display("FAIL fault[%0d] got flt=%0b we=%0b ret=%0d want 1 0 %0d", i, wb.load_fault, wb.rf_we, wb.retired, CNT_W'(expRet));
            end
            step();
            checks++; if (wb.load_fault !== 1'b0) begin errors++; $display("FAIL fault_pulse[%0d] got %0b want 0", i, wb.load_fault); end
        end
        drive(2'd0, 3'b000, 2'd0, 5'd0, 1'b1);
        step();
        wb.in_valid = 1'b0;
        expRet++;
        checks++; if (wb.rf_we !== 1'b0 || wb.retired !== CNT_W'(expRet)) begin errors++; $display("FAIL x0_write got we=%0b ret=%0d want 0 %0d", wb.rf_we, wb.retired, CNT_W'(expRet)); end
        drive(2'd0, 3'b000, 2'd0, 5'd9, 1'b0);
        step();
        wb.in_valid = 1'b0;
        expRet++;
        checks++; if (wb.rf_we !== 1'b0) begin errors++; $display("FAIL no_regwrite got we=%0b want 0", wb.rf_we); end
    endtask

    task automatic test_stall_flush();
        drive(2'd0, 3'b000, 2'd0, 5'd11, 1'b1);
        step();
        expRet++;
        wb.SrcData[31:0] = 32'h0000_5555;
        drive(2'd0, 3'b000, 2'd0, 5'd12, 1'b1);
        wb.stall = 1'b1;
        #1;
        checks++; if (wb.in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %0b want 0", wb.in_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (wb.rf_we !== 1'b0 || wb.rf_wdata !== 32'h0000_1234 || wb.rf_waddr !== 5'd11 || wb.retired !== CNT_W'(expRet)) begin
                errors++;
                $display("FAIL stall[%0d] got we=%0b %h rd=%0d ret=%0d want 0 00001234 11 %0d", i, wb.rf_we, wb.rf_wdata, wb.rf_waddr, wb.retired, CNT_W'(expRet));
            end
        end
        wb.flush = 1'b1;
        step();
        checks++; if (wb.rf_we !== 1'b0 || wb.rf_wdata !== 32'h0000_1234 || wb.retired !== CNT_W'(expRet)) begin errors++; $display("FAIL flush_stall got we=%0b %h ret=%0d", wb.rf_we, wb.rf_wdata, wb.retired); end
        wb.stall = 1'b0;
        step();
        checks++; if (wb.rf_we !== 1'b0 || wb.retired !== CNT_W'(expRet)) begin errors++; $display("FAIL flush_only got we=%0b ret=%0d want 0 %0d", wb.rf_we, wb.retired, CNT_W'(expRet)); end
        wb.flush = 1'b0;
        step();
        wb.in_valid = 1'b0;
        expRet++;
        checks++; if (wb.rf_we !== 1'b1 || wb.rf_wdata !== 32'h0000_5555 || wb.rf_waddr !== 5'd12) begin errors++; $display("FAIL resume got we=%0b %h rd=%0d want 1 00005555 12", wb.rf_we, wb.rf_wdata, wb.rf_waddr); end
        wb.SrcData[31:0] = 32'h0000_1234;
    endtask

    task automatic test_reset_midstream();
        drive(2'd3, 3'b000, 2'd0, 5'd9, 1'b1);
        step();
        wb.in_valid = 1'b0;
        checks++; if (wb.rf_we !== 1'b1) begin errors++; $display("FAIL mid_pre got we=%0b want 1", wb.rf_we); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (wb.rf_we !== 1'b0 || wb.fwd_valid !== 1'b0 || wb.rf_wdata !== 32'h0 || wb.rf_waddr !== 5'd0 || wb.retired !== 4'd0 || wb.load_fault !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got we=%0b fwd=%0b %h rd=%0d ret=%0d flt=%0b want all 0", wb.rf_we, wb.fwd_valid, wb.rf_wdata, wb.rf_waddr, wb.retired, wb.load_fault);
        end
        @(negedge clk);
        rst_n = 1'b1;
        expRet = 0;
        drive(2'd0, 3'b000, 2'd0, 5'd10, 1'b1);
        step();
        wb.in_valid = 1'b0;
        expRet++;
        checks++; if (wb.retired !== 4'd1 || wb.rf_we !== 1'b1 || wb.rf_wdata !== 32'h0000_1234) begin errors++; $display("FAIL post_reset got ret=%0d we=%0b %h want 1 1 00001234", wb.retired, wb.rf_we, wb.rf_wdata); end
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        expRet = 0;
        for (int i = 0; i < 17; i++) begin
            wb.SrcData[31:0] = 32'hA000_0000 + 32'(i);
            drive(2'd0, 3'b000, 2'd0, 5'(i + 1), 1'b1);
            step();
            expRet++;
            if (wb.rf_we === 1'b1) pulses++;
            checks++;
            if (wb.rf_we !== 1'b1 || wb.rf_wdata !== 32'hA000_0000 + 32'(i) || wb.rf_waddr !== 5'(i + 1)) begin
                errors++;
                $display("FAIL b2b[%0d] got we=%0b %h rd=%0d want 1 %h %0d", i, wb.rf_we, wb.rf_wdata, wb.rf_waddr, 32'hA000_0000 + 32'(i), i + 1);
            end
        end
        wb.in_valid = 1'b0;
        step();
        if (wb.rf_we === 1'b1) pulses++;
        checks++; if (pulses != 17) begin errors++; $display("FAIL b2b_pulses got %0d want 17", pulses); end
        checks++; if (wb.retired !== 4'd1) begin errors++; $display("FAIL wrap_retired got %0d want 1", wb.retired); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        expRet = 0;
        test_reset();
        test_src_select();
        test_load_format();
        test_faults();
        test_stall_flush();
        test_reset_midstream();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Registered, parametrised register-writeback stage for the single-cycle RISC-V core, replacing the two-input ALU/memory result select. It chooses among NUM_SRC result sources and formats load data by width, sign and byte offset. It flags misaligned or illegal loads and suppresses writes to x0. It drives the register-file write port and a forwarding port one cycle after acceptance, and it counts retired instructions.

## Interface
Parameters:
- XLEN, 32: datapath width; must be ≥ 32.
- NUM_SRC, 4: number of result sources; must be ≥ 2. Source 0 = ALU, 1 = memory (load-formatted), 2 = PC+4, 3 = immediate.
- SEL_W, $clog2(NUM_SRC): width of ResultSrc.
- REG_ADDR_W, 5: register address width.
- CNT_W, 64: retire counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  an instruction is presented for writeback.
- in_ready  out  1  stage can accept; equals !stall.
- stall  in  1  hold; no capture this cycle.
- flush  in  1  kill; no capture this cycle, output valid cleared.
- SrcData  in  NUM_SRC*XLEN  packed sources; source k at [k*XLEN +: XLEN].
- ResultSrc  in  SEL_W  source select.
- LoadFunct3  in  3  load type; used only when ResultSrc == 1.
- ByteOffset  in  2  load address bits [1:0].
- RegWrite  in  1  instruction writes rd.
- Rd  in  REG_ADDR_W  destination register.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  REG_ADDR_W  write address.
- rf_wdata  out  XLEN  write data.
- fwd_valid  out  1  forwarding entry valid; equals rf_we.
- load_fault  out  1  one-cycle pulse for a misaligned or illegal load.
- retired  out  CNT_W  count of accepted, unflushed instructions.

## Operation
- Accept: `accept = in_valid && !stall && !flush`.
- Load formatting applies when ResultSrc == 1. Select byte lane ByteOffset, or half lane ByteOffset[1].
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: sign-extend SrcData[1] word bits [31:0] to XLEN.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
- Fault conditions:
  - Funct3 011, 110 or 111 is illegal.
  - LH/LHU with ByteOffset[0] = 1 is misaligned.
  - LW with ByteOffset ≠ 0 is misaligned.
- Fault response: a faulting accepted load sets load_fault for one cycle, writes nothing, and still counts as retired.
- ResultSrc ≥ NUM_SRC selects 0 (data = 0). The write still follows RegWrite.
- Write qualification: `we_next = accept && RegWrite && (Rd != 0) && !fault`.
- Output registers on every edge:
  - rf_we ← we_next.
  - load_fault ← accept && fault.
- rf_waddr/rf_wdata load only on accept and otherwise hold their last value. rf_we therefore never repeats for one instruction.
- retired increments by 1 on each accept. It wraps modulo 2^CNT_W with no saturation.
- flush and stall both asserted: flush dominates; rf_we ← 0 and there is no capture.

## Timing
- Latency is one cycle. An instruction accepted at edge N shows rf_we/rf_wdata between edge N and edge N+1. The register file writes at edge N+1.
- Throughput is one instruction per cycle while stall = 0.
- in_ready is combinational from stall only. There is no path from in_valid to in_ready.
- Reset (rst_n = 0, asynchronous assert) clears rf_we, rf_waddr, rf_wdata, load_fault, fwd_valid and retired to 0.
- Reset release is synchronous to the first clk edge. An instruction presented during reset is dropped and not counted.
- Reset asserted while rf_we = 1 deasserts rf_we immediately, without waiting for a clock edge.
- The stage has no state machine. State is the output register plus the retire counter.

## Test plan
- Source select:
  - ALU: SrcData[0] = 0x0000_1234, ResultSrc = 0, Rd = 5, RegWrite = 1 → next cycle rf_we = 1, rf_waddr = 5, rf_wdata = 0x0000_1234, retired = 1.
  - PC+4: repeat with ResultSrc = 2 and SrcData[2] = 0x0000_0104 → rf_wdata = 0x0000_0104.
- Load formatting with ReadData = 0x80FF_7F01:
  - LB off 3 → 0xFFFF_FF80.
  - LBU off 3 → 0x0000_0080.
  - LH off 2 → 0xFFFF_80FF.
  - LHU off 0 → 0x0000_7F01.
  - LW off 0 → 0x80FF_7F01.
- Faults and x0:
  - LW off 2 → load_fault pulses, rf_we = 0, retired still increments.
  - Funct3 = 011 → fault.
  - Rd = 0 with RegWrite = 1 → rf_we = 0.
- Stall and flush:
  - stall = 1 for 3 cycles with in_valid = 1 → in_ready = 0, rf_we = 0, rf_wdata held, retired unchanged.
  - flush = 1 together with stall = 1 → no capture.
- Reset mid-stream: assert rst_n = 0 asynchronously between edges while rf_we = 1 → all outputs 0 immediately. After release, the first accept sets retired = 1.
- Counter wrap: CNT_W = 4, issue 17 accepts → retired = 1. Back-to-back accepts produce 17 rf_we pulses, none duplicated.
